// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo sample buffer feeding the I2S transmitter
module audio_sample_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int LOW_WATER = 4
) (
   input  logic          MasterCLK,
   input  logic          Reset,
   input  logic          Enable,
   input  logic          Flush,
   input  logic [31:0]   WrData,
   input  logic          WrEn,
   input  logic          SyncCLK,
   input  logic          ClrFlags,
   output logic [31:0]   SampleOut,
   output logic [AW:0]   Level,
   output logic          Full,
   output logic          Empty,
   output logic          LowWater,
   output logic          Underrun,
   output logic          Overflow
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] LOW_L   = (AW+1)'(LOW_WATER);

   logic [31:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        sync_d;

   logic pop_req;
   logic push_ok;
   logic push_drop;
   logic pop_ok;
   logic pop_under;

   // Status decode from the registered pointers; the extra pointer bit separates full from empty
   always_comb begin
      Level     = wr_ptr - rd_ptr;
      Full      = (Level == DEPTH_L);
      Empty     = (Level == '0);
      LowWater  = (Level <= LOW_L);
      pop_req   = SyncCLK & ~sync_d;
      push_ok   = WrEn & ~Full;
      push_drop = WrEn & Full;
      pop_ok    = pop_req & Enable & ~Empty;
      pop_under = pop_req & Enable & Empty;
   end

   // SyncCLK already lives in this clock domain, so one delay stage is enough for edge detect
   always_ff @(posedge MasterCLK or posedge Reset) begin
      if (Reset) sync_d <= 1'b0;
      else       sync_d <= SyncCLK;
   end

   // Sample storage; contents are meaningless until written so they carry no reset
   always_ff @(posedge MasterCLK) begin
      if (push_ok && !Flush) mem[wr_ptr[AW-1:0]] <= WrData;
   end

   // Pointer and output sample update; flush overrides any push or pop in the same cycle
   always_ff @(posedge MasterCLK or posedge Reset) begin
      if (Reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         SampleOut <= '0;
      end else if (Flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         SampleOut <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_req) begin
            if (pop_ok) begin
               SampleOut <= mem[rd_ptr[AW-1:0]];
               rd_ptr    <= rd_ptr + 1'b1;
            end else begin
               SampleOut <= '0;
            end
         end
      end
   end

   // Sticky error flags; a set event in the same cycle as ClrFlags wins
   always_ff @(posedge MasterCLK or posedge Reset) begin
      if (Reset) begin
         Underrun <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         if (pop_under && !Flush) Underrun <= 1'b1;
         else if (ClrFlags)       Underrun <= 1'b0;
         if (push_drop && !Flush) Overflow <= 1'b1;
         else if (ClrFlags)       Overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - scoreboard bench for audio_sample_fifo
module tb_audio_sample_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int LOW_WATER = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          fl = 1'b0;
   logic [31:0]   wd = '0;
   logic          we = 1'b0;
   logic          sc = 1'b0;
   logic          cf = 1'b0;
   logic [31:0]   sample_out;
   logic [AW:0]   level;
   logic          full, empty, low_water, underrun, overflow;

   audio_sample_fifo #(.DEPTH(DEPTH), .AW(AW), .LOW_WATER(LOW_WATER)) dut (
      .MasterCLK(clk), .Reset(rst), .Enable(en), .Flush(fl), .WrData(wd), .WrEn(we),
      .SyncCLK(sc), .ClrFlags(cf), .SampleOut(sample_out), .Level(level), .Full(full),
      .Empty(empty), .LowWater(low_water), .Underrun(underrun), .Overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      int          lvl;
      logic        u;
      logic        o;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_q[$];
   logic [31:0] m_sample = '0;
   logic        m_under = 1'b0;
   logic        m_over  = 1'b0;
   logic        m_sync  = 1'b0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Behavioural model: a word queue plus the two sticky flags
   task automatic model_step();
      bit pop_req, was_full, was_empty, set_u, set_o;
      exp_t e;
      if (rst) begin
         m_q.delete();
         m_sample = '0; m_under = 0; m_over = 0; m_sync = 0;
      end else begin
         pop_req   = sc && !m_sync;
         m_sync    = sc;
         was_full  = (m_q.size() == DEPTH);
         was_empty = (m_q.size() == 0);
         set_u = 0; set_o = 0;
         if (fl) begin
            m_q.delete();
            m_sample = '0;
         end else begin
            set_o = we && was_full;
            set_u = pop_req && en && was_empty;
            if (pop_req) begin
               if (en && !was_empty) m_sample = m_q.pop_front();
               else                  m_sample = '0;
            end
            if (we && !was_full) m_q.push_back(wd);
         end
         if (set_u) m_under = 1; else if (cf) m_under = 0;
         if (set_o) m_over  = 1; else if (cf) m_over  = 0;
      end
      e.s = m_sample; e.lvl = m_q.size(); e.u = m_under; e.o = m_over;
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic r, input logic e_, input logic f_, input logic [31:0] d,
                        input logic w, input logic s, input logic c);
      @(negedge clk);
      #1;
      rst = r; en = e_; fl = f_; wd = d; we = w; sc = s; cf = c;
      model_step();
   endtask

   task automatic push(input logic [31:0] d);
      cycle(0, en, 0, d, 1, 0, 0);
   endtask

   task automatic pop_once();
      cycle(0, en, 0, '0, 0, 1, 0);
      cycle(0, en, 0, '0, 0, 0, 0);
   endtask

   // Monitor: one expected record per clock, compared half a cycle after the edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sample_out", sample_out, e.s);
            chk("level", 32'(level), 32'(e.lvl));
            chk("full", 32'(full), 32'(e.lvl == DEPTH));
            chk("empty", 32'(empty), 32'(e.lvl == 0));
            chk("low_water", 32'(low_water), 32'(e.lvl <= LOW_WATER));
            chk("underrun", 32'(underrun), 32'(e.u));
            chk("overflow", 32'(overflow), 32'(e.o));
         end
      end
   end

   initial begin
      // reset state
      cycle(1, 0, 0, '0, 0, 0, 0);
      cycle(1, 0, 0, '0, 0, 0, 0);
      cycle(0, 1, 0, '0, 0, 0, 0);

      // three pushes, three pops
      push(32'd26); push(32'd19891); push(32'd40);
      repeat (3) pop_once();

      // fill past full, then drain
      for (int i = 1; i <= 17; i++) push(32'(i));
      repeat (16) pop_once();
      cycle(0, 1, 0, '0, 0, 0, 1);

      // underrun on empty, then clear
      pop_once();
      cycle(0, 1, 0, '0, 0, 0, 1);

      // simultaneous push/pop with one entry, then with none
      push(32'hAAAA_0001);
      cycle(0, 1, 0, 32'hBBBB_0002, 1, 1, 0);
      cycle(0, 1, 0, '0, 0, 0, 0);
      pop_once();
      cycle(0, 1, 0, 32'hCCCC_0003, 1, 1, 0);
      cycle(0, 1, 0, '0, 0, 0, 1);
      cycle(0, 1, 1, '0, 0, 0, 0);
      cycle(0, 1, 0, '0, 0, 0, 0);

      // reset mid-stream at level 8 takes effect without a clock edge
      for (int i = 0; i < 9; i++) push(32'h100 + 32'(i));
      pop_once();
      cycle(1, 1, 0, '0, 0, 0, 0);
      #1;
      chk("async_rst_sample", sample_out, 32'd0);
      chk("async_rst_level", 32'(level), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      cycle(0, 1, 0, '0, 0, 0, 0);

      // disabled pops leave the buffer alone
      push(32'h11); push(32'h22); push(32'h33);
      en = 0;
      repeat (3) pop_once();
      en = 1;
      cycle(0, 1, 1, '0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 399) == 0),
               ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 99) == 0),
               $urandom(),
               ($urandom_range(0, 99) < 55),
               $urandom_range(0, 1),
               ($urandom_range(0, 29) == 0));
      end
      cycle(0, 1, 0, '0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
